// File: rtl/snake_dir_input_if.sv
// Signal bundle between the board buttons / movement logic and the direction front end.
// The master drives raw buttons and the move tick; the slave returns the conditioned request.
interface snake_dir_input_if;
    logic [3:0] btn_raw;
    logic       move_tick;
    logic [3:0] direction;
    logic [3:0] btn_level;
    logic [3:0] press_pulse;
    logic       overrun;

    modport master (
        output btn_raw,
        output move_tick,
        input  direction,
        input  btn_level,
        input  press_pulse,
        input  overrun
    );

    modport slave (
        input  btn_raw,
        input  move_tick,
        output direction,
        output btn_level,
        output press_pulse,
        output overrun
    );
endinterface

// File: rtl/snake_dir_input.sv
// Conditions four bouncing push-buttons into a held one-hot direction request.
// Bit order: [0]=left [1]=down [2]=up [3]=right.
module snake_dir_input #(
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned CNT_W           = 16
) (
    input logic              clk,
    input logic              clear,
    snake_dir_input_if.slave bus
);
    localparam logic [CNT_W-1:0] CntLast = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic {StIdle, StPending} state_e;

    logic [3:0]       s1_q, s1_d, s2_q, s2_d;
    logic [CNT_W-1:0] cnt_q [4];
    logic [CNT_W-1:0] cnt_d [4];
    logic [3:0]       level_q, level_d, level_dly_q, level_dly_d;
    logic [3:0]       pulse_q, pulse_d;
    logic [3:0]       dir_q, dir_d, winner;
    logic             overrun_q, overrun_d;
    state_e           state_q, state_d;

    // Synchronizer, per-button debounce and rising-edge detect.
    always_comb begin
        s1_d    = bus.btn_raw;
        s2_d    = s1_q;
        level_d = level_q;
        for (int i = 0; i < 4; i++) begin
            cnt_d[i] = '0;
            if (s2_q[i] != level_q[i]) begin
                if (cnt_q[i] == CntLast) begin
                    level_d[i] = s2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
        level_dly_d = level_q;
        // Pulse lands the cycle after btn_level rises.
        pulse_d     = level_q & ~level_dly_q;
    end

    // Fixed priority among simultaneous presses: right > left > down > up.
    always_comb begin
        winner = 4'b0000;
        if (pulse_q[3]) begin
            winner = 4'b1000;
        end else if (pulse_q[0]) begin
            winner = 4'b0001;
        end else if (pulse_q[1]) begin
            winner = 4'b0010;
        end else if (pulse_q[2]) begin
            winner = 4'b0100;
        end
    end

    always_comb begin
        state_d   = state_q;
        dir_d     = dir_q;
        overrun_d = overrun_q;
        case (state_q)
            StIdle: begin
                if (|pulse_q) begin
                    dir_d   = winner;
                    state_d = StPending;
                end
            end
            StPending: begin
                if (|pulse_q) begin
                    dir_d = winner;
                    // A same-cycle tick consumes the old request, so nothing is lost.
                    if (!bus.move_tick) begin
                        overrun_d = 1'b1;
                    end
                end else if (bus.move_tick) begin
                    dir_d   = 4'b0000;
                    state_d = StIdle;
                end
            end
            default: begin
                dir_d   = 4'b0000;
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            s1_q        <= '0;
            s2_q        <= '0;
            level_q     <= '0;
            level_dly_q <= '0;
            pulse_q     <= '0;
            dir_q       <= '0;
            overrun_q   <= 1'b0;
            state_q     <= StIdle;
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            s1_q        <= s1_d;
            s2_q        <= s2_d;
            level_q     <= level_d;
            level_dly_q <= level_dly_d;
            pulse_q     <= pulse_d;
            dir_q       <= dir_d;
            overrun_q   <= overrun_d;
            state_q     <= state_d;
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign bus.direction   = dir_q;
    assign bus.btn_level   = level_q;
    assign bus.press_pulse = pulse_q;
    assign bus.overrun     = overrun_q;
endmodule
